dmem_mmio_sink: RTL and testbench
=================================

Name: dmem_mmio_sink

Overview:
Data-side responder for the single-cycle RISC-V core. It accepts the core's store interface (MemWrite, ALUResult as address, WriteData) and returns ReadData. Word RAM occupies the low address range. A small MMIO window provides a buffered console output stream with a valid/ready drain, a TOHOST completion register and status/count readback. Benches stop on done instead of on a timeout.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words (power of 2); RAM spans byte addresses 0 .. 4*RAM_WORDS-1.
FIFO_DEPTH, 8, console FIFO entries (power of 2, >=2).
MMIO_BASE, 32'h0000_FF00, base of the MMIO window (16-byte aligned, outside RAM range).

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
MemWrite  in  1  store strobe from core, one store per asserted cycle
ALUResult  in  32  byte address (bits [1:0] ignored, word access only)
WriteData  in  32  store data
ReadData  out  32  load data, combinational from ALUResult
out_valid  out  1  console FIFO non-empty
out_data  out  32  FIFO head word (valid while out_valid)
out_ready  in  1  consumer accepts head when out_valid && out_ready
done  out  1  sticky, set by the first TOHOST store
exit_code  out  32  WriteData captured by the first TOHOST store
store_count  out  32  number of MemWrite cycles since reset, saturating
overflow  out  1  sticky, a console push was dropped because the FIFO was full

Behaviour:
- Decode uses the word address ALUResult[31:2]. RAM hit when ALUResult < 4*RAM_WORDS. MMIO hit when ALUResult[31:4] == MMIO_BASE[31:4]. Offsets: 0x0 CONSOLE, 0x4 TOHOST, 0x8 STATUS, 0xC COUNT.
- Reset (rst=1 at an edge): FIFO pointers and count = 0, out_valid=0, done=0, exit_code=0, store_count=0, overflow=0. RAM contents are not cleared. Reset overrides every simultaneous store and pop.
- out_data equals the FIFO head regardless of out_valid. It is don't-care when the FIFO is empty.
- RAM store: when MemWrite and RAM hit, RAM[word] <= WriteData at the edge. Read is asynchronous (0 cycle latency), so a load in the cycle after a store returns the new data.
- ReadData mapping:
  - RAM hit: RAM word.
  - CONSOLE: 0.
  - TOHOST: {31'b0, done}.
  - STATUS: {overflow, done, FIFO full, FIFO empty, count in [27:0] zero-extended}, i.e. bit31 overflow, bit30 done, bit29 full, bit28 empty.
  - COUNT: store_count.
  - Any unmapped address: 0.
- CONSOLE store pushes WriteData. Pop occurs when out_valid && out_ready.
  - Not full: push accepted. The count stays the same if a pop happens in the same cycle, otherwise it increments.
  - Full with a simultaneous pop: push accepted and the count stays at FIFO_DEPTH.
  - Full with no pop: push dropped, overflow <= 1, FIFO unchanged.
  - Pop when empty: not possible (out_valid=0), no state change.
- Pointers wrap modulo FIFO_DEPTH. Strict FIFO order.
- TOHOST store:
  - If done==0: done <= 1 and exit_code <= WriteData.
  - If done==1: ignored (first value wins until reset).
  - Stores after done are still processed (RAM, FIFO, count).
- store_count increments on every MemWrite cycle (any address, mapped or not). It holds at 32'hFFFF_FFFF.
- Stores to STATUS, COUNT or unmapped addresses only increment store_count.

Test Plan:
1. Reset, store 0xDEADBEEF to addr 84, next cycle ALUResult=84 with MemWrite=0 -> ReadData=0xDEADBEEF same cycle; store_count=1.
2. out_ready=0, 9 CONSOLE stores of values 1..9 with FIFO_DEPTH=8 -> after the 8th store STATUS reads full=1 and count=8; the 9th store sets overflow=1; then out_ready=1 drains 1..8 in order over 8 cycles, out_valid=0 afterwards.
3. FIFO full, out_ready=1 and a CONSOLE store of 0x55 in the same cycle -> head advances, count stays 8, 0x55 becomes last entry, overflow unchanged.
4. TOHOST store 0x2A then TOHOST store 0x7 -> done=1 one edge after the first store, exit_code=0x2A both times, TOHOST read returns 1.
5. rst=1 asserted for 1 cycle mid-drain, with a simultaneous CONSOLE store -> all flags, FIFO count and store_count are 0 after that edge, out_valid=0; a RAM word written before reset still reads back its old value.
6. Store to addr 0x8000 (unmapped) -> no RAM change, ReadData=0, store_count increments; store_count preset near max (long run or force) saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/dmem_mmio_sink.sv
// Data-side responder for the single-cycle RISC-V core.
// Word RAM in the low address range plus a 16-byte MMIO window holding a
// buffered console stream (valid/ready drain), a TOHOST completion register
// and STATUS/COUNT readback.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   MemWrite          store strobe, one store per asserted cycle
//   ALUResult         byte address (word access, bits [1:0] ignored)
//   WriteData         store data
//   ReadData          load data, combinational from ALUResult
//   out_valid         console FIFO non-empty
//   out_data          console FIFO head word
//   out_ready         consumer accepts head when out_valid && out_ready
//   done, exit_code   sticky completion flag and first TOHOST value
//   store_count       saturating count of MemWrite cycles since reset
//   overflow          sticky, a console push was dropped on a full FIFO
module dmem_mmio_sink #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        done,
  output logic [31:0] exit_code,
  output logic [31:0] store_count,
  output logic        overflow
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  localparam logic [1:0] OFF_CONSOLE = 2'd0;
  localparam logic [1:0] OFF_TOHOST  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_COUNT   = 2'd3;

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              done_q;
  logic [31:0]       exit_code_q;
  logic [31:0]       store_cnt_q;
  logic              overflow_q;

  // Address decode
  logic              ram_hit, mmio_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        mmio_off;

  assign ram_hit  = {1'b0, ALUResult} < RAM_BYTES;
  assign mmio_hit = ALUResult[31:4] == MMIO_BASE[31:4];
  assign ram_idx  = ALUResult[RAM_AW+1:2];
  assign mmio_off = ALUResult[3:2];

  // FIFO handshake; a full FIFO still accepts a push when the head pops
  logic fifo_full, fifo_empty, pop, push_req, push_ok, push_drop, tohost_wr;

  assign fifo_full  = fifo_cnt == CNT_W'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  assign pop        = out_valid && out_ready;
  assign push_req   = MemWrite && mmio_hit && (mmio_off == OFF_CONSOLE);
  assign push_ok    = push_req && (!fifo_full || pop);
  assign push_drop  = push_req && fifo_full && !pop;
  assign tohost_wr  = MemWrite && mmio_hit && (mmio_off == OFF_TOHOST);

  // RAM storage, not cleared by reset; reset still blocks a coincident store
  always_ff @(posedge clk) begin
    if (!rst && MemWrite && ram_hit) begin
      ram[ram_idx] <= WriteData;
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      fifo_mem[wr_ptr] <= WriteData;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push_ok && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  // Completion, overflow and store counter
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b0;
      exit_code_q <= '0;
      store_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (tohost_wr && !done_q) begin
        done_q      <= 1'b1;
        exit_code_q <= WriteData;
      end
      if (push_drop) overflow_q <= 1'b1;
      if (MemWrite && (store_cnt_q != 32'hFFFF_FFFF)) begin
        store_cnt_q <= store_cnt_q + 32'd1;
      end
    end
  end

  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_mem[rd_ptr];
  assign done        = done_q;
  assign exit_code   = exit_code_q;
  assign store_count = store_cnt_q;
  assign overflow    = overflow_q;

  // Load data mux
  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = ram[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_CONSOLE: ReadData = '0;
        OFF_TOHOST:  ReadData = {31'b0, done_q};
        OFF_STATUS:  ReadData = {overflow_q, done_q, fifo_full, fifo_empty,
                                 28'(fifo_cnt)};
        OFF_COUNT:   ReadData = store_cnt_q;
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_sink.sv
module tb_dmem_mmio_sink;

  localparam logic [31:0] BASE    = 32'h0000_FF00;
  localparam logic [31:0] CONSOLE = BASE + 32'h0;
  localparam logic [31:0] TOHOST  = BASE + 32'h4;
  localparam logic [31:0] STATUS  = BASE + 32'h8;
  localparam logic [31:0] COUNT   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst, MemWrite, out_ready;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData, out_data, exit_code, store_count;
  logic        out_valid, done, overflow;

  dmem_mmio_sink dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .done(done),
    .exit_code(exit_code), .store_count(store_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] ram_m [64];
  bit          ram_v [64];
  logic [31:0] q_m [$];
  bit          done_m, ovf_m;
  logic [31:0] exit_m, sc_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Expected load value; known=0 for RAM words never stored
  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int unsigned sz;
    sz = q_m.size();
    v = 32'h0;
    known = 1'b1;
    if (a < 32'd256) begin
      v = ram_m[a >> 2];
      known = ram_v[a >> 2];
    end else if ((a >> 4) == (BASE >> 4)) begin
      case ((a >> 2) % 4)
        1: v = {31'b0, done_m};
        2: v = {ovf_m, done_m, sz == 8, sz == 0, 28'(sz)};
        3: v = sc_m;
        default: v = 32'h0;
      endcase
    end
  endtask

  task automatic model_step(input bit r, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input bit rdy);
    bit popped;
    if (r) begin
      q_m.delete();
      done_m = 0; ovf_m = 0; exit_m = 0; sc_m = 0;
      return;
    end
    popped = 0;
    if (rdy && q_m.size() > 0) begin
      void'(q_m.pop_front());
      popped = 1;
    end
    if (we) begin
      if (sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 1;
      if (a < 32'd256) begin
        ram_m[a >> 2] = d;
        ram_v[a >> 2] = 1;
      end else if (a == CONSOLE || (a >> 2) == (CONSOLE >> 2)) begin
        if (q_m.size() < 8) q_m.push_back(d);
        else ovf_m = 1;
      end else if ((a >> 2) == (TOHOST >> 2)) begin
        if (!done_m) begin
          done_m = 1;
          exit_m = d;
        end
      end
    end
    if (popped && q_m.size() > 8) ovf_m = 1;
  endtask

  // One clock: drive at negedge, check load, clock, check registered state
  task automatic cycle(input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy);
    logic [31:0] ev;
    bit known;
    rst = r; MemWrite = we; ALUResult = a; WriteData = d; out_ready = rdy;
    #1;
    model_read(a, ev, known);
    if (known && !r) check_eq($sformatf("ReadData@%08h", a), ReadData, ev);
    @(posedge clk);
    model_step(r, we, a, d, rdy);
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), 32'(q_m.size() != 0));
    if (q_m.size() != 0) check_eq("out_data", out_data, q_m[0]);
    check_eq("done", 32'(done), 32'(done_m));
    check_eq("exit_code", exit_code, exit_m);
    check_eq("store_count", store_count, sc_m);
    check_eq("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 64; i++) ram_v[i] = 0;
    done_m = 0; ovf_m = 0; exit_m = 0; sc_m = 0;
    rst = 1; MemWrite = 0; ALUResult = 0; WriteData = 0; out_ready = 0;
    @(negedge clk);

    // 1: reset, store then load-after-store
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 32'd84, 32'hDEAD_BEEF, 0);
    cycle(0, 0, 32'd84, 0, 0);
    check_eq("t1_load", ReadData, 32'hDEAD_BEEF);
    check_eq("t1_count", store_count, 32'd1);

    // 2: fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) cycle(0, 1, CONSOLE, 32'(i), 0);
    cycle(0, 0, STATUS, 0, 0);
    check_eq("t2_status_full", ReadData, 32'h2000_0008);
    cycle(0, 1, CONSOLE, 32'd9, 0);
    check_eq("t2_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check_eq("t2_drain", out_data, 32'(i));
      cycle(0, 0, COUNT, 0, 1);
    end
    check_eq("t2_empty", 32'(out_valid), 32'd0);

    // 3: push into full FIFO while popping
    for (int i = 0; i < 8; i++) cycle(0, 1, CONSOLE, 32'h100 + 32'(i), 0);
    cycle(0, 1, CONSOLE, 32'h55, 1);
    cycle(0, 0, STATUS, 0, 0);
    check_eq("t3_status", ReadData, 32'hA000_0008);
    check_eq("t3_tail", q_m[7], 32'h55);

    // 4: TOHOST first value wins
    cycle(0, 1, TOHOST, 32'h2A, 0);
    check_eq("t4_done", 32'(done), 32'd1);
    cycle(0, 1, TOHOST, 32'h7, 0);
    cycle(0, 0, TOHOST, 0, 0);
    check_eq("t4_read", ReadData, 32'd1);
    check_eq("t4_exit", exit_code, 32'h2A);

    // 5: reset mid-drain with a coincident console store
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, CONSOLE, 32'h77, 1);
    check_eq("t5_cnt", store_count, 32'd0);
    check_eq("t5_valid", 32'(out_valid), 32'd0);
    cycle(0, 0, 32'd84, 0, 0);
    check_eq("t5_ram_kept", ReadData, 32'hDEAD_BEEF);

    // 6: unmapped store, then counter saturation
    cycle(0, 1, 32'h8000, 32'h1234_5678, 0);
    cycle(0, 0, 32'h8000, 0, 0);
    check_eq("t6_unmapped", ReadData, 32'h0);
    force dut.store_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.store_cnt_q;
    sc_m = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h8000, 0, 0);
    check_eq("t6_saturate", store_count, 32'hFFFF_FFFF);
    cycle(0, 0, COUNT, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: a = ($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
        3, 4, 5: a = CONSOLE;
        6:       a = TOHOST;
        7:       a = STATUS;
        8:       a = COUNT;
        default: a = 32'h100 + 32'($urandom_range(0, 32'hFDFF)) & ~32'h0;
      endcase
      if (sel == 9 && (a >> 4) == (BASE >> 4)) a = 32'h8000;
      cycle($urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0, a, $urandom,
            $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
